// File: rtl/cache_bus_pkg.sv
// Shared constants and FSM state encodings for the cache-to-memory arbiter.
// States are one-hot so each FSM output decodes from a single state bit.
package cache_bus_pkg;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam int         LINE_OFF_W   = 4;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_REQ  = 3'b010,
    R_RESP = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_REQ  = 3'b010,
    W_WAIT = 3'b100
  } wr_state_e;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and bridge-side signals of the arbiter in one bundle.
// slave = arbiter view, master = caches plus memory bridge.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              ic_rd_req, dc_rd_req;
  logic [2:0]        ic_rd_type, dc_rd_type;
  logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr;
  logic              ic_rd_rdy, dc_rd_rdy;
  logic              ic_ret_valid, dc_ret_valid;
  logic              ic_ret_last, dc_ret_last;
  logic [31:0]       ic_ret_data, dc_ret_data;

  logic              dc_wr_req;
  logic [2:0]        dc_wr_type;
  logic [3:0]        dc_wr_wstrb;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [LINE_W-1:0] dc_wr_data;
  logic              dc_wr_rdy;

  logic              mem_rd_req;
  logic [2:0]        mem_rd_type;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_rdy;
  logic              mem_ret_valid, mem_ret_last;
  logic [31:0]       mem_ret_data;

  logic              mem_wr_req;
  logic [2:0]        mem_wr_type;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [3:0]        mem_wr_wstrb;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_wr_rdy, mem_wr_done;

  modport slave (
    input  ic_rd_req, ic_rd_type, ic_rd_addr, dc_rd_req, dc_rd_type, dc_rd_addr,
    output ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last,
    output ic_ret_data, dc_ret_data,
    input  dc_wr_req, dc_wr_type, dc_wr_wstrb, dc_wr_addr, dc_wr_data,
    output dc_wr_rdy,
    output mem_rd_req, mem_rd_type, mem_rd_addr,
    input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    input  mem_wr_rdy, mem_wr_done
  );

  modport master (
    output ic_rd_req, ic_rd_type, ic_rd_addr, dc_rd_req, dc_rd_type, dc_rd_addr,
    input  ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last,
    input  ic_ret_data, dc_ret_data,
    output dc_wr_req, dc_wr_type, dc_wr_wstrb, dc_wr_addr, dc_wr_data,
    input  dc_wr_rdy,
    input  mem_rd_req, mem_rd_type, mem_rd_addr,
    output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    output mem_wr_rdy, mem_wr_done
  );
endinterface

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// Two-way read grant (bit0 = dcache, bit1 = icache); combinational pick, registered priority.
// With RR_EN=0 the dcache always wins a tie and the pointer has no effect.
module arb_rr2 #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_gnt_ic
);
  logic r_prio_ic;
  logic w_gnt_ic;

  always_comb begin
    w_gnt_ic = i_req[1];
    if (i_req == 2'b11) w_gnt_ic = (RR_EN != 0) ? r_prio_ic : 1'b0;
  end

  // Whoever wins now yields the tie to the other master next time.
  always_ff @(posedge clk) begin
    if (reset) r_prio_ic <= 1'b0;
    else if (i_take && (i_req != 2'b00)) r_prio_ic <= ~w_gnt_ic;
  end

  assign o_gnt_ic = w_gnt_ic;
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one bridge read port (one line in flight) and one buffered write-back between icache and dcache.
// Reads to a line with a pending or just-accepted write-back are held until the write completes.
module cache_mem_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int RR_EN  = 1
) (
  input logic clk,
  input logic reset,
  cache_mem_arbiter_if.slave io_bus
);
  rd_state_e         r_state, w_rnext;
  wr_state_e         r_wstate, w_wnext;
  logic              r_gnt_ic;
  logic [1:0]        r_beat_cnt;
  logic [2:0]        r_wb_type;
  logic [3:0]        r_wb_wstrb;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [LINE_W-1:0] r_wb_data;

  logic w_wr_acc, w_ic_haz, w_dc_haz, w_ic_elig, w_dc_elig, w_take, w_arb_gnt_ic;

  assign w_wr_acc = io_bus.dc_wr_req && (r_wstate == W_IDLE);

  // Line match against the buffered write and against a write being accepted this very cycle.
  assign w_ic_haz =
    ((r_wstate != W_IDLE) && (io_bus.ic_rd_addr[ADDR_W-1:LINE_OFF_W] == r_wb_addr[ADDR_W-1:LINE_OFF_W])) ||
    (w_wr_acc && (io_bus.ic_rd_addr[ADDR_W-1:LINE_OFF_W] == io_bus.dc_wr_addr[ADDR_W-1:LINE_OFF_W]));
  assign w_dc_haz =
    ((r_wstate != W_IDLE) && (io_bus.dc_rd_addr[ADDR_W-1:LINE_OFF_W] == r_wb_addr[ADDR_W-1:LINE_OFF_W])) ||
    (w_wr_acc && (io_bus.dc_rd_addr[ADDR_W-1:LINE_OFF_W] == io_bus.dc_wr_addr[ADDR_W-1:LINE_OFF_W]));

  assign w_ic_elig = io_bus.ic_rd_req && !w_ic_haz;
  assign w_dc_elig = io_bus.dc_rd_req && !w_dc_haz;

  arb_rr2 #(.RR_EN(RR_EN)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({w_ic_elig, w_dc_elig}),
    .i_take   (w_take),
    .o_gnt_ic (w_arb_gnt_ic)
  );

  always_comb begin
    w_rnext             = r_state;
    w_take              = 1'b0;
    io_bus.mem_rd_req   = 1'b0;
    io_bus.mem_rd_type  = '0;
    io_bus.mem_rd_addr  = '0;
    io_bus.ic_rd_rdy    = 1'b0;
    io_bus.dc_rd_rdy    = 1'b0;
    io_bus.ic_ret_valid = 1'b0;
    io_bus.dc_ret_valid = 1'b0;
    io_bus.ic_ret_last  = 1'b0;
    io_bus.dc_ret_last  = 1'b0;
    io_bus.ic_ret_data  = '0;
    io_bus.dc_ret_data  = '0;
    unique case (r_state)
      R_IDLE: begin
        if (w_ic_elig || w_dc_elig) begin
          w_take  = 1'b1;
          w_rnext = R_REQ;
        end
      end
      R_REQ: begin
        io_bus.mem_rd_req  = 1'b1;
        io_bus.mem_rd_type = r_gnt_ic ? io_bus.ic_rd_type : io_bus.dc_rd_type;
        io_bus.mem_rd_addr = r_gnt_ic ? io_bus.ic_rd_addr : io_bus.dc_rd_addr;
        if (io_bus.mem_rd_rdy) begin
          io_bus.ic_rd_rdy = r_gnt_ic;
          io_bus.dc_rd_rdy = !r_gnt_ic;
          w_rnext          = R_RESP;
        end
      end
      R_RESP: begin
        io_bus.ic_ret_valid = r_gnt_ic && io_bus.mem_ret_valid;
        io_bus.dc_ret_valid = !r_gnt_ic && io_bus.mem_ret_valid;
        io_bus.ic_ret_last  = r_gnt_ic && io_bus.mem_ret_last;
        io_bus.dc_ret_last  = !r_gnt_ic && io_bus.mem_ret_last;
        io_bus.ic_ret_data  = io_bus.mem_ret_data;
        io_bus.dc_ret_data  = io_bus.mem_ret_data;
        if (io_bus.mem_ret_valid && io_bus.mem_ret_last) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_gnt_ic   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_rnext;
      if (w_take) r_gnt_ic <= w_arb_gnt_ic;
      if ((r_state == R_REQ) && (w_rnext == R_RESP)) r_beat_cnt <= '0;
      else if ((r_state == R_RESP) && io_bus.mem_ret_valid) r_beat_cnt <= r_beat_cnt + 2'd1;
    end
  end

  always_comb begin
    w_wnext           = r_wstate;
    io_bus.dc_wr_rdy  = 1'b0;
    io_bus.mem_wr_req = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        io_bus.dc_wr_rdy = 1'b1;
        if (io_bus.dc_wr_req) w_wnext = W_REQ;
      end
      W_REQ: begin
        io_bus.mem_wr_req = 1'b1;
        if (io_bus.mem_wr_rdy) w_wnext = W_WAIT;
      end
      W_WAIT: begin
        if (io_bus.mem_wr_done) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate   <= W_IDLE;
      r_wb_type  <= '0;
      r_wb_wstrb <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wstate <= w_wnext;
      if (w_wr_acc) begin
        r_wb_type  <= io_bus.dc_wr_type;
        r_wb_wstrb <= io_bus.dc_wr_wstrb;
        r_wb_addr  <= io_bus.dc_wr_addr;
        r_wb_data  <= io_bus.dc_wr_data;
      end
    end
  end

  assign io_bus.mem_wr_type  = r_wb_type;
  assign io_bus.mem_wr_wstrb = r_wb_wstrb;
  assign io_bus.mem_wr_addr  = r_wb_addr;
  assign io_bus.mem_wr_data  = r_wb_data;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: read routing, round-robin order, RAW hold, write buffer, reset.
module tb_cache_mem_arbiter;
  import cache_bus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [127:0] line_a, line_junk;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_EN(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_rd_req = 0; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = '0;
    bus.dc_rd_req = 0; bus.dc_rd_type = RD_TYPE_LINE; bus.dc_rd_addr = '0;
    bus.dc_wr_req = 0; bus.dc_wr_type = '0; bus.dc_wr_wstrb = '0;
    bus.dc_wr_addr = '0; bus.dc_wr_data = '0;
    bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_data = '0;
    bus.mem_wr_rdy = 0; bus.mem_wr_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_rd_req", bus.mem_rd_req, 0);
    chk("rst_mem_wr_req", bus.mem_wr_req, 0);
    chk("rst_dc_wr_rdy", bus.dc_wr_rdy, 1);
    chk("rst_ic_ret_valid", bus.ic_ret_valid, 0);
    tick();
    reset = 1'b0;
  endtask

  // Called at posedge+1; waits for the read request, accepts it and returns 4 beats 0x11..0x44.
  task automatic serve_read(input logic exp_ic, input logic [31:0] exp_addr,
                            input logic done_last);
    int n = 0;
    while (!bus.mem_rd_req && n < 20) begin tick(); n++; end
    chk("rd_req_seen", bus.mem_rd_req, 1);
    chk("rd_addr", bus.mem_rd_addr, exp_addr);
    bus.mem_rd_rdy = 1;
    @(negedge clk);
    chk("ic_rd_rdy", bus.ic_rd_rdy, exp_ic);
    chk("dc_rd_rdy", bus.dc_rd_rdy, !exp_ic);
    tick();
    bus.mem_rd_rdy = 0;
    if (exp_ic) bus.ic_rd_req = 0; else bus.dc_rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ret_valid = 1;
      bus.mem_ret_data  = 32'h11 * (i + 1);
      bus.mem_ret_last  = (i == 3);
      bus.mem_wr_done   = (i == 3) && done_last;
      @(negedge clk);
      chk("ic_ret_valid", bus.ic_ret_valid, exp_ic);
      chk("dc_ret_valid", bus.dc_ret_valid, !exp_ic);
      chk("ret_data", exp_ic ? bus.ic_ret_data : bus.dc_ret_data, 32'h11 * (i + 1));
      tick();
    end
    bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_wr_done = 0;
  endtask

  initial begin
    line_a    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    line_junk = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    clear_inputs();
    tick();

    // T1: single icache read.
    do_reset();
    bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h1c000040;
    tick();
    @(negedge clk);
    chk("t1_mem_rd_req", bus.mem_rd_req, 1);
    chk("t1_rd_type", bus.mem_rd_type, RD_TYPE_LINE);
    chk("t1_no_rdy_yet", bus.ic_rd_rdy, 0);
    tick();
    serve_read(1, 32'h1c000040, 0);
    @(negedge clk);
    chk("t1_idle", bus.mem_rd_req, 0);
    chk("t1_beat_wrap", dut.r_beat_cnt, 2'd0);
    tick();

    // T2: simultaneous requests alternate D,I,D,I after reset.
    do_reset();
    bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h2000;
    bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h3000;
    serve_read(0, 32'h3000, 0); bus.dc_rd_req = 1;
    serve_read(1, 32'h2000, 0); bus.ic_rd_req = 1;
    serve_read(0, 32'h3000, 0);
    serve_read(1, 32'h2000, 0);

    // T3/T4: write-back holds a read to the same line; write buffer keeps the latched line.
    do_reset();
    bus.dc_wr_req = 1; bus.dc_wr_addr = 32'h1230; bus.dc_wr_data = line_a;
    bus.dc_wr_type = 3'b001; bus.dc_wr_wstrb = 4'hf;
    @(negedge clk);
    chk("t4_wr_rdy_before", bus.dc_wr_rdy, 1);
    tick();
    bus.dc_wr_req = 0; bus.dc_wr_data = line_junk; bus.mem_wr_rdy = 1;
    bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h123c;
    bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h8000;
    @(negedge clk);
    chk("t4_mem_wr_req", bus.mem_wr_req, 1);
    chk("t4_mem_wr_addr", bus.mem_wr_addr, 32'h1230);
    chk("t4_mem_wr_data", bus.mem_wr_data, line_a);
    chk("t4_mem_wr_wstrb", bus.mem_wr_wstrb, 4'hf);
    chk("t4_wr_rdy_busy", bus.dc_wr_rdy, 0);
    tick();
    bus.mem_wr_rdy = 0;
    @(negedge clk);
    chk("t4_wr_req_drop", bus.mem_wr_req, 0);
    tick();
    serve_read(1, 32'h8000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_dc_held", bus.mem_rd_req, 0);
      tick();
    end
    bus.mem_wr_done = 1;
    @(negedge clk);
    chk("t4_wr_rdy_at_done", bus.dc_wr_rdy, 0);
    tick();
    bus.mem_wr_done = 0;
    @(negedge clk);
    chk("t4_wr_rdy_after", bus.dc_wr_rdy, 1);
    chk("t3_not_yet", bus.mem_rd_req, 0);
    tick();
    @(negedge clk);
    chk("t3_dc_granted", bus.mem_rd_req, 1);
    tick();
    serve_read(0, 32'h123c, 0);

    // T5: reset in the middle of a line return.
    do_reset();
    bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h5000;
    serve_read_partial();
    @(negedge clk);
    chk("t5_beat_cnt", dut.r_beat_cnt, 2'd2);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_rd_req", bus.mem_rd_req, 0);
    chk("t5_ic_ret_valid", bus.ic_ret_valid, 0);
    chk("t5_ic_ret_data", bus.ic_ret_data, 0);
    chk("t5_mem_wr_req", bus.mem_wr_req, 0);
    chk("t5_dc_wr_rdy", bus.dc_wr_rdy, 1);
    tick();
    reset = 1'b0;
    bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'h99; bus.mem_wr_done = 1;
    @(negedge clk);
    chk("t5_stray_ic", bus.ic_ret_valid, 0);
    chk("t5_stray_dc", bus.dc_ret_valid, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("t5_wr_rdy_stays", bus.dc_wr_rdy, 1);
    tick();

    // T6: write done and last beat together release a hazarded read.
    do_reset();
    bus.dc_wr_req = 1; bus.dc_wr_addr = 32'h4400; bus.dc_wr_data = line_a;
    tick();
    bus.dc_wr_req = 0; bus.mem_wr_rdy = 1;
    bus.dc_rd_req = 1; bus.dc_rd_addr = 32'h4408;
    bus.ic_rd_req = 1; bus.ic_rd_addr = 32'h6000;
    tick();
    bus.mem_wr_rdy = 0;
    serve_read(1, 32'h6000, 1);
    @(negedge clk);
    chk("t6_wr_idle", bus.dc_wr_rdy, 1);
    chk("t6_rd_idle", bus.mem_rd_req, 0);
    tick();
    @(negedge clk);
    chk("t6_dc_granted", bus.mem_rd_req, 1);
    tick();
    serve_read(0, 32'h4408, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Accepts an outstanding icache read and delivers only two beats.
  task automatic serve_read_partial();
    int n = 0;
    while (!bus.mem_rd_req && n < 20) begin tick(); n++; end
    chk("t5_rd_req_seen", bus.mem_rd_req, 1);
    bus.mem_rd_rdy = 1;
    tick();
    bus.mem_rd_rdy = 0; bus.ic_rd_req = 0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_ret_valid = 1; bus.mem_ret_data = 32'h11 * (i + 1);
      tick();
    end
    bus.mem_ret_valid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
